// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, load-use stalls,
// MEM-resolved redirects, post-reset fill and MDU stall window. Optional macro: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned RA_W        = 5,
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_mdu_start,
  input  logic            mdu_done,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic            mem_branch_taken,
  input  logic            mem_jump,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            mdu_abort,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt,
`endif
  output logic            mdu_err
);

  localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned MduW  = $clog2(MDU_TIMEOUT);

  typedef enum logic [1:0] {StBoot, StRun, StMduWait} state_e;

  state_e           state_q, state_d;
  logic [BootW-1:0] boot_cnt_q, boot_cnt_d;
  logic [MduW-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic             mdu_err_q, mdu_err_d;

  logic redirect, load_use, boot_last, mdu_last, in_boot;

  assign redirect  = mem_branch_taken | mem_jump;
  assign load_use  = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign boot_last = (boot_cnt_q == BootW'(BOOT_CYCLES - 1));
  assign mdu_last  = (mdu_cnt_q == MduW'(MDU_TIMEOUT - 1));
  // Outputs take their reset values combinationally while rst is high, not one cycle late.
  assign in_boot   = rst || (state_q == StBoot);
  assign mdu_err   = mdu_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      boot_cnt_q <= '0;
      mdu_cnt_q  <= '0;
      mdu_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      mdu_cnt_q  <= mdu_cnt_d;
      mdu_err_q  <= mdu_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    mdu_cnt_d  = mdu_cnt_q;
    mdu_err_d  = mdu_err_q;
    unique case (state_q)
      StBoot: begin
        if (boot_last) state_d = StRun;
        else           boot_cnt_d = boot_cnt_q + 1'b1;
      end
      StRun: begin
        if (!redirect && ex_mdu_start) begin
          state_d   = StMduWait;
          mdu_cnt_d = '0;
        end
      end
      StMduWait: begin
        if (redirect || mdu_done) begin
          state_d = StRun;
        end else if (mdu_last) begin
          state_d   = StRun;
          mdu_err_d = 1'b1;
        end else begin
          mdu_cnt_d = mdu_cnt_q + 1'b1;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mdu_abort    = 1'b0;
    if (in_boot) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mdu_abort    = (state_q == StMduWait);
    end else if (state_q == StMduWait) begin
      if (mdu_done) begin
        // Release cycle: result writes through, all stages advance.
      end else if (mdu_last) begin
        mdu_abort    = 1'b1;
        ex_mem_flush = 1'b1;
      end else begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
      end
    end else if (ex_mdu_start) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // MEM beats WB so the youngest producer wins; x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!in_boot) begin
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1))    fwd_a = 2'b10;
      else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1))  fwd_a = 2'b01;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2))    fwd_b = 2'b10;
      else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2))  fwd_b = 2'b01;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q != StBoot) begin
      if (!pc_en)   stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default parameters).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_mem_read, ex_mdu_start, mdu_done, mem_reg_write, wb_reg_write;
  logic       mem_branch_taken, mem_jump;
  logic       pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       mdu_abort, mdu_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_abort(mdu_abort),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mdu_err(mdu_err)
  );

  always #5 clk = ~clk;

  // ctl = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush}
  localparam logic [5:0] CtlBoot   = 6'b000_111;
  localparam logic [5:0] CtlRun    = 6'b111_000;
  localparam logic [5:0] CtlLdUse  = 6'b001_010;
  localparam logic [5:0] CtlMdu    = 6'b000_001;
  localparam logic [5:0] CtlTmo    = 6'b111_001;
  localparam logic [5:0] CtlRedir  = 6'b111_111;

  function automatic logic [5:0] ctl();
    return {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_mem_read, ex_mdu_start, mdu_done, mem_reg_write, wb_reg_write} = '0;
    {mem_branch_taken, mem_jump} = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // 1: reset and boot fill
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_ctl", 32'(ctl()), 32'(CtlBoot));
      tick();
    end
    chk("rst_err", 32'(mdu_err), 32'd0);
    rst = 1'b0;
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("boot_ctl", 32'(ctl()), 32'(CtlBoot));
      chk("boot_fwd_a", 32'(fwd_a), 32'd0);
      chk("boot_abort", 32'(mdu_abort), 32'd0);
      tick();
    end
    chk("run_ctl", 32'(ctl()), 32'(CtlRun));

    // 2: forwarding priority
    wb_rd = 5'd5; wb_reg_write = 1'b1; #1;
    chk("fwd_a_mem", 32'(fwd_a), 32'd2);
    mem_rd = 5'd0; #1;
    chk("fwd_a_wb", 32'(fwd_a), 32'd1);
    wb_rd = 5'd0; #1;
    chk("fwd_a_none", 32'(fwd_a), 32'd0);
    ex_rs2 = 5'd7; wb_rd = 5'd7; mem_rd = 5'd9; #1;
    chk("fwd_b_wb", 32'(fwd_b), 32'd1);
    mem_rd = 5'd7; mem_reg_write = 1'b0; #1;
    chk("fwd_b_memnowr", 32'(fwd_b), 32'd1);
    clear_inputs(); #1;

    // 3: load-use
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; #1;
    chk("lduse_ctl", 32'(ctl()), 32'(CtlLdUse));
    tick();
    clear_inputs(); #1;
    chk("lduse_after", 32'(ctl()), 32'(CtlRun));
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; #1;
    chk("lduse_x0", 32'(ctl()), 32'(CtlRun));
    clear_inputs();
    mdu_done = 1'b1; #1;
    chk("done_run_ign", 32'(ctl()), 32'(CtlRun));
    tick();
    mdu_done = 1'b0; #1;
    chk("done_run_ign2", 32'(ctl()), 32'(CtlRun));

    // 4a: MDU with done after 5 wait cycles
    ex_mdu_start = 1'b1; #1;
    chk("mdu_entry", 32'(ctl()), 32'(CtlMdu));
    tick();
    ex_mdu_start = 1'b0;
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; #1;
    for (int i = 0; i < 5; i++) begin
      chk("mdu_wait", 32'(ctl()), 32'(CtlMdu));
      tick();
    end
    clear_inputs();
    mdu_done = 1'b1; #1;
    chk("mdu_release", 32'(ctl()), 32'(CtlRun));
    chk("mdu_rel_abort", 32'(mdu_abort), 32'd0);
    tick();
    mdu_done = 1'b0; #1;
    chk("mdu_back_run", 32'(ctl()), 32'(CtlRun));

    // 4b: MDU timeout
    ex_mdu_start = 1'b1; tick();
    ex_mdu_start = 1'b0; #1;
    for (int i = 0; i < 63; i++) begin
      chk("tmo_wait", 32'({ctl(), mdu_abort}), 32'({CtlMdu, 1'b0}));
      tick();
    end
    chk("tmo_ctl", 32'(ctl()), 32'(CtlTmo));
    chk("tmo_abort", 32'(mdu_abort), 32'd1);
    chk("tmo_err_pre", 32'(mdu_err), 32'd0);
    tick();
    chk("tmo_abort_pulse", 32'(mdu_abort), 32'd0);
    chk("tmo_err", 32'(mdu_err), 32'd1);
    chk("tmo_run", 32'(ctl()), 32'(CtlRun));

    // 5: redirect during MDU_WAIT (with same-cycle done) and with load-use
    ex_mdu_start = 1'b1; tick();
    ex_mdu_start = 1'b0; #1;
    chk("redir_mdu_wait", 32'(ctl()), 32'(CtlMdu));
    tick();
    mem_jump = 1'b1; mdu_done = 1'b1; #1;
    chk("redir_mdu_ctl", 32'(ctl()), 32'(CtlRedir));
    chk("redir_mdu_abort", 32'(mdu_abort), 32'd1);
    tick();
    clear_inputs(); #1;
    chk("redir_mdu_run", 32'(ctl()), 32'(CtlRun));
    chk("redir_mdu_noab", 32'(mdu_abort), 32'd0);
    chk("err_sticky", 32'(mdu_err), 32'd1);
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; mem_branch_taken = 1'b1; #1;
    chk("redir_ld_ctl", 32'(ctl()), 32'(CtlRedir));
    chk("redir_ld_abort", 32'(mdu_abort), 32'd0);
    tick();
    clear_inputs(); #1;

    // reset in the middle of an MDU wait
    ex_mdu_start = 1'b1; tick();
    ex_mdu_start = 1'b0;
    rst = 1'b1; #1;
    chk("rst_mid_ctl", 32'(ctl()), 32'(CtlBoot));
    chk("rst_mid_abort", 32'(mdu_abort), 32'd0);
    tick();
    chk("rst_mid_err", 32'(mdu_err), 32'd0);
    rst = 1'b0; #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_rst_stall", stall_cnt, 32'd0);
    chk("perf_rst_flush", flush_cnt, 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("reboot_ctl", 32'(ctl()), 32'(CtlBoot));
      tick();
    end
    chk("reboot_run", 32'(ctl()), 32'(CtlRun));

    // 6: one load-use stall then one redirect
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; tick();
    clear_inputs();
    mem_jump = 1'b1; tick();
    clear_inputs(); #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall", stall_cnt, 32'd1);
    chk("perf_flush", flush_cnt, 32'd1);
`endif
    chk("final_run", 32'(ctl()), 32'(CtlRun));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
